stepper_phase_monitor: RTL

//  Reader end of the stepper coil interface: watches one 4-bit full-step coil bus (driver signal_out)
//  and decodes steps, direction and absolute position. Flags skipped or illegal coil patterns.

---
 rtl/stepper_pkg.sv | 44 ++++
 rtl/phase_sync_hold.sv | 50 +++++
 rtl/stepper_phase_monitor.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper coil interface: full-step coil patterns,
// monitor FSM encoding and the pattern classifier used by the phase monitor.
package stepper_pkg;

  localparam logic [3:0] PHASE_0   = 4'b0011;
  localparam logic [3:0] PHASE_1   = 4'b0110;
  localparam logic [3:0] PHASE_2   = 4'b1100;
  localparam logic [3:0] PHASE_3   = 4'b1001;
  localparam logic [3:0] PHASE_OFF = 4'b0000;

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } mon_state_t;

  typedef enum logic [1:0] {
    PAT_OFF     = 2'd0,
    PAT_VALID   = 2'd1,
    PAT_ILLEGAL = 2'd2
  } pat_kind_t;

  typedef struct packed {
    pat_kind_t  kind;
    logic [1:0] idx;
  } pat_info_t;

  // Maps a coil pattern to its position in the forward full-step sequence.
  function automatic pat_info_t decode_pattern(input logic [3:0] pat);
    pat_info_t info;
    info.kind = PAT_VALID;
    info.idx  = 2'd0;
    case (pat)
      PHASE_0:   info.idx  = 2'd0;
      PHASE_1:   info.idx  = 2'd1;
      PHASE_2:   info.idx  = 2'd2;
      PHASE_3:   info.idx  = 2'd3;
      PHASE_OFF: info.kind = PAT_OFF;
      default:   info.kind = PAT_ILLEGAL;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/phase_sync_hold.sv
// Resynchronizes the asynchronous coil bus and accepts a pattern once it has
// been stable for MIN_HOLD cycles and differs from the last accepted one.
module phase_sync_hold
  import stepper_pkg::*;
#(
  parameter int MIN_HOLD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] phase_in,
  output logic [3:0] pattern,
  output logic       accept_strobe
);

  localparam int                HOLD_W   = $clog2(MIN_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);

  logic [3:0]        sync_1;
  logic [3:0]        sync_2;
  logic [HOLD_W-1:0] run_len;
  logic              accept;

  // run_len counts the cycles sync_2 has held its current value, saturating.
  assign accept = (run_len == HOLD_MAX) && (sync_2 != pattern);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two synchronizer stages.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_1        <= PHASE_OFF;
      sync_2        <= PHASE_OFF;
      run_len       <= '0;
      pattern       <= PHASE_OFF;
      accept_strobe <= 1'b0;
    end else begin
      sync_1 <= phase_in;
      sync_2 <= sync_1;
      if (sync_1 != sync_2) begin
        run_len <= HOLD_W'(1);
      end else if (run_len != HOLD_MAX) begin
        run_len <= run_len + 1'b1;
      end
      accept_strobe <= accept;
      if (accept) begin
        pattern <= sync_2;
      end
    end
  end

endmodule

// File: rtl/stepper_phase_monitor.sv
// Reader end of a stepper coil bus: decodes steps, direction and a saturating
// absolute position, flags skipped/illegal patterns and tracks motion activity.
module stepper_phase_monitor
  import stepper_pkg::*;
#(
  parameter int POS_W    = 16,
  parameter int MIN_HOLD = 2,
  parameter int IDLE_CYC = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              phase_in,
  input  logic                    home,
  input  logic                    clr_fault,
  output logic signed [POS_W-1:0] position,
  output logic                    step_pulse,
  output logic                    dir,
  output logic                    moving,
  output logic                    locked,
  output logic                    err_skip,
  output logic                    err_ill,
  output logic                    sat
);

  localparam logic signed [POS_W-1:0] POS_MAX  = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN  = {1'b1, {(POS_W-1){1'b0}}};
  localparam int                      IDLE_W   = $clog2(IDLE_CYC + 1);
  localparam logic [IDLE_W-1:0]       IDLE_MAX = IDLE_W'(IDLE_CYC);

  mon_state_t        state;
  mon_state_t        state_next;
  logic [3:0]        acc_pattern;
  logic              acc_strobe;
  pat_info_t         acc_info;
  logic [1:0]        ref_idx;
  logic [1:0]        delta;
  logic              step_fwd;
  logic              step_rev;
  logic              skip_evt;
  logic              ill_evt;
  logic              ref_load;
  logic [IDLE_W-1:0] idle_cnt;
  logic              armed;

  phase_sync_hold #(
    .MIN_HOLD(MIN_HOLD)
  ) u_sync (
    .clk          (clk),
    .rst          (rst),
    .phase_in     (phase_in),
    .pattern      (acc_pattern),
    .accept_strobe(acc_strobe)
  );

  // Modulo-4 distance from the reference index: 1 forward, 3 reverse, 2 skip.
  assign acc_info = decode_pattern(acc_pattern);
  assign delta    = acc_info.idx - ref_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= UNLOCK;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      UNLOCK: if (acc_strobe && acc_info.kind == PAT_VALID) state_next = TRACK;
      TRACK: begin
        if (acc_strobe && (acc_info.kind == PAT_ILLEGAL ||
                           (acc_info.kind == PAT_VALID && delta == 2'd2))) begin
          state_next = FAULT;
        end
      end
      FAULT:   if (clr_fault) state_next = UNLOCK;
      default: state_next = UNLOCK;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    locked   = 1'b0;
    step_fwd = 1'b0;
    step_rev = 1'b0;
    skip_evt = 1'b0;
    ill_evt  = 1'b0;
    ref_load = 1'b0;
    case (state)
      UNLOCK: begin
        if (acc_strobe && acc_info.kind == PAT_ILLEGAL) ill_evt  = 1'b1;
        if (acc_strobe && acc_info.kind == PAT_VALID)   ref_load = 1'b1;
      end
      TRACK: begin
        locked = 1'b1;
        if (acc_strobe && acc_info.kind == PAT_ILLEGAL) ill_evt = 1'b1;
        if (acc_strobe && acc_info.kind == PAT_VALID) begin
          step_fwd = (delta == 2'd1);
          step_rev = (delta == 2'd3);
          skip_evt = (delta == 2'd2);
          ref_load = (delta != 2'd0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_idx    <= 2'd0;
      position   <= '0;
      step_pulse <= 1'b0;
      dir        <= 1'b0;
      err_skip   <= 1'b0;
      err_ill    <= 1'b0;
      sat        <= 1'b0;
      idle_cnt   <= '0;
      armed      <= 1'b0;
    end else begin
      step_pulse <= step_fwd | step_rev;
      if (ref_load) ref_idx <= acc_info.idx;
      if (step_fwd) begin
        dir <= 1'b1;
      end else if (step_rev) begin
        dir <= 1'b0;
      end
      if (skip_evt) err_skip <= 1'b1;
      if (ill_evt)  err_ill  <= 1'b1;
      if ((step_fwd && position == POS_MAX) || (step_rev && position == POS_MIN)) begin
        sat <= 1'b1;
      end
      // Home wins over any step decoded in the same cycle.
      if (home) begin
        position <= '0;
      end else if (step_fwd && position != POS_MAX) begin
        position <= position + 1'b1;
      end else if (step_rev && position != POS_MIN) begin
        position <= position - 1'b1;
      end
      if (step_fwd || step_rev) begin
        idle_cnt <= '0;
        armed    <= 1'b1;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  // armed keeps moving low until the first step after reset.
  assign moving = armed && (idle_cnt < IDLE_MAX);

endmodule
